// File: rtl/vpu_sram_rbank_arb.sv
// -----------------------------------------------------------------------------
// vpu_sram_rbank_arb
//   Per-bank read arbiter for the operand SRAM. Several read ports share one
//   SRAM bank. A port is granted round-robin and keeps the grant for a whole
//   burst, up to and including the beat flagged rlast. Each fired beat becomes
//   a registered read of the bank. The returned data is steered back to the
//   port that issued the read, so reads in flight still drain to the correct
//   port after ownership moves on.
//
// Ports
//   clk, rst_n    clock and asynchronous active-low reset
//   req_i         per-port request
//   rid_i         per-port target bank (packed, RID_W per port)
//   addr_i        per-port beat address (packed, ADDR_W per port)
//   reb_i         per-port read enable, active-low (0 = read beat)
//   rlast_i       per-port last-beat-of-burst flag
//   ack_o         one-hot grant, registered
//   rdata_o       per-port read data (packed, DATA_W per port), zero unless valid
//   rvalid_o      one-hot read data valid
//   sram_ren_o    bank read enable (registered)
//   sram_addr_o   bank word address (registered, holds between reads)
//   sram_rdata_i  bank read data, valid RD_LAT cycles after sram_ren_o
// -----------------------------------------------------------------------------
module vpu_sram_rbank_arb #(
  parameter int NUM_REQ = 3,
  parameter int BANK_ID = 0,
  parameter int RID_W   = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 256,
  parameter int RD_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*RID_W-1:0]    rid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]          reb_i,
  input  logic [NUM_REQ-1:0]          rlast_i,
  output logic [NUM_REQ-1:0]          ack_o,
  output logic [NUM_REQ*DATA_W-1:0]   rdata_o,
  output logic [NUM_REQ-1:0]          rvalid_o,
  output logic                        sram_ren_o,
  output logic [ADDR_W-1:0]           sram_addr_o,
  input  logic [DATA_W-1:0]           sram_rdata_i
);

  localparam int          IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NREQ_U = NUM_REQ;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [IDX_W-1:0]            r_owner;
  logic [IDX_W-1:0]            w_owner_nxt;
  logic [IDX_W-1:0]            r_rr_ptr;
  logic [IDX_W-1:0]            w_rr_nxt;
  logic [NUM_REQ-1:0]          r_ack;
  logic [NUM_REQ-1:0]          w_ack_nxt;
  logic [ADDR_W-1:0]           r_addr;

  // Stage 0 is the cycle sram_ren_o is high; stage RD_LAT is the data-valid cycle.
  logic [RD_LAT:0]             r_pv;
  logic [RD_LAT:0][IDX_W-1:0]  r_pid;

  logic [NUM_REQ-1:0]          w_elig;
  logic                        w_found;
  logic [IDX_W-1:0]            w_pick;
  logic                        w_own_req;
  logic                        w_own_reb;
  logic                        w_own_last;
  logic [ADDR_W-1:0]           w_own_addr;
  logic                        w_fire;
  logic [NUM_REQ-1:0]          w_rv;

  // Eligibility: requesting and targeting this bank.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      w_elig[i] = req_i[i] && (rid_i[i*RID_W +: RID_W] == RID_W'(BANK_ID));
    end
  end

  // Round-robin search upward from r_rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned off = 0; off < NREQ_U; off++) begin
      idx = (32'(r_rr_ptr) + off) % NREQ_U;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(idx);
      end
    end
  end

  // Owner's signals. The owner's rid is not looked at: the lock holds.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_reb  = 1'b1;
    w_own_last = 1'b0;
    w_own_addr = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (r_owner == IDX_W'(i)) begin
        w_own_req  = req_i[i];
        w_own_reb  = reb_i[i];
        w_own_last = rlast_i[i];
        w_own_addr = addr_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_fire = (r_state == ST_BUSY) && w_own_req && !w_own_reb;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_ack_nxt   = r_ack;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = w_pick;
          w_ack_nxt   = NUM_REQ'(1) << w_pick;
        end
      end
      ST_BUSY: begin
        if (w_fire && w_own_last) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
          w_ack_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ack_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_ack    <= '0;
      r_addr   <= '0;
      r_pv     <= '0;
      r_pid    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_ack    <= w_ack_nxt;
      if (w_fire) begin
        r_addr <= w_own_addr;
      end
      r_pv  <= {r_pv[RD_LAT-1:0], w_fire};
      r_pid <= {r_pid[RD_LAT-1:0], r_owner};
    end
  end

  // Return routing: drains independently of the current owner.
  always_comb begin
    w_rv    = '0;
    rdata_o = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      w_rv[i] = r_pv[RD_LAT] && (r_pid[RD_LAT] == IDX_W'(i));
      rdata_o[i*DATA_W +: DATA_W] = w_rv[i] ? sram_rdata_i : '0;
    end
  end

  assign rvalid_o    = w_rv;
  assign ack_o       = r_ack;
  assign sram_ren_o  = r_pv[0];
  assign sram_addr_o = r_addr;

  a_ack_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack_o));
  a_rvalid_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rvalid_o));
  a_ren_after_fire: assert property (@(posedge clk) disable iff (!rst_n)
                                     sram_ren_o |-> $past(w_fire));
  // Owner dropping req before its rlast beat leaves the bank locked.
  a_owner_holds_req: assert property (@(posedge clk) disable iff (!rst_n)
                                      (r_state == ST_BUSY) |-> w_own_req);

endmodule

// File: tb/tb_vpu_sram_rbank_arb.sv
module tb_vpu_sram_rbank_arb;

  localparam int NUM_REQ = 3;
  localparam int BANK_ID = 1;
  localparam int RID_W   = 3;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 256;
  localparam int RD_LAT  = 3;
  localparam int NCYC    = 3000;

  logic                       clk;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_i;
  logic [NUM_REQ*RID_W-1:0]   rid_i;
  logic [NUM_REQ*ADDR_W-1:0]  addr_i;
  logic [NUM_REQ-1:0]         reb_i;
  logic [NUM_REQ-1:0]         rlast_i;
  logic [NUM_REQ-1:0]         ack_o;
  logic [NUM_REQ*DATA_W-1:0]  rdata_o;
  logic [NUM_REQ-1:0]         rvalid_o;
  logic                       sram_ren_o;
  logic [ADDR_W-1:0]          sram_addr_o;
  logic [DATA_W-1:0]          sram_rdata_i;

  vpu_sram_rbank_arb #(
    .NUM_REQ (NUM_REQ),
    .BANK_ID (BANK_ID),
    .RID_W   (RID_W),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .rid_i        (rid_i),
    .addr_i       (addr_i),
    .reb_i        (reb_i),
    .rlast_i      (rlast_i),
    .ack_o        (ack_o),
    .rdata_o      (rdata_o),
    .rvalid_o     (rvalid_o),
    .sram_ren_o   (sram_ren_o),
    .sram_addr_o  (sram_addr_o),
    .sram_rdata_i (sram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Bank contents as a pure function of the word address.
  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    for (int w = 0; w < DATA_W / 32; w++) begin
      v[w*32 +: 32] = (32'(a) * 32'h9E37_79B1) + (32'(w) * 32'h0101_0101);
    end
    return v;
  endfunction

  // Reference model: owner/round-robin bookkeeping plus a per-cycle log of fires.
  bit               m_busy;
  int               m_owner;
  int               m_rr;
  logic [ADDR_W-1:0] m_addr;
  bit               h_fire [NCYC];
  int               h_port [NCYC];
  logic [ADDR_W-1:0] h_addr [NCYC];

  // SRAM macro emulation history (environment only).
  bit               d_ren  [NCYC];
  logic [ADDR_W-1:0] d_addr [NCYC];

  // Port masters.
  int               p_left [NUM_REQ];
  int               p_hold [NUM_REQ];
  logic [ADDR_W-1:0] p_addr [NUM_REQ];

  // Values driven this cycle.
  bit               v_req  [NUM_REQ];
  logic [RID_W-1:0] v_rid  [NUM_REQ];
  logic [ADDR_W-1:0] v_addr [NUM_REQ];
  bit               v_reb  [NUM_REQ];
  bit               v_last [NUM_REQ];

  task automatic drive_ports(input int k);
    bit cont;
    int stall_pct, noel_pct, start_pct, maxlen;
    cont      = (k < 400);
    stall_pct = cont ? 0 : 30;
    noel_pct  = cont ? 0 : 20;
    start_pct = cont ? 100 : 40;
    maxlen    = cont ? 2 : 5;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (p_hold[i] > 0) p_hold[i]--;
      if (p_left[i] == 0 && p_hold[i] == 0 && $urandom_range(0, 99) < start_pct) begin
        if ($urandom_range(0, 99) < noel_pct) begin
          p_hold[i] = $urandom_range(1, 6);
          v_rid[i]  = RID_W'(BANK_ID + 1 + $urandom_range(0, 6));
        end else begin
          p_left[i] = cont ? 2 : $urandom_range(1, maxlen);
          p_addr[i] = ADDR_W'($urandom);
        end
      end
      v_req[i] = (p_left[i] > 0) || (p_hold[i] > 0);
      if (p_left[i] > 0) begin
        v_rid[i]  = RID_W'(BANK_ID);
        // Owner scrambling its rid mid-burst must not break the lock.
        if (!cont && m_busy && m_owner == i && $urandom_range(0, 3) == 0)
          v_rid[i] = RID_W'($urandom);
        v_addr[i] = p_addr[i];
        v_last[i] = (p_left[i] == 1);
        v_reb[i]  = ($urandom_range(0, 99) < stall_pct);
      end else begin
        if (p_hold[i] == 0) v_rid[i] = RID_W'($urandom);
        v_addr[i] = ADDR_W'($urandom);
        v_last[i] = 1'($urandom);
        v_reb[i]  = 1'($urandom);
      end
      req_i[i]                     = v_req[i];
      rid_i[i*RID_W +: RID_W]      = v_rid[i];
      addr_i[i*ADDR_W +: ADDR_W]   = v_addr[i];
      reb_i[i]                     = v_reb[i];
      rlast_i[i]                   = v_last[i];
    end
  endtask

  task automatic drive_sram(input int k);
    if (k >= RD_LAT && d_ren[k-RD_LAT])
      sram_rdata_i = mem_val(d_addr[k-RD_LAT]);
    else
      for (int w = 0; w < DATA_W / 32; w++) sram_rdata_i[w*32 +: 32] = $urandom;
  endtask

  task automatic check_and_model(input int k);
    logic [NUM_REQ-1:0] e_ack, e_rv;
    logic [DATA_W-1:0]  e_data;
    bit                 e_ren;
    int                 j, rv_port;
    bit                 fire;

    d_ren[k]  = sram_ren_o;
    d_addr[k] = sram_addr_o;

    if (!rst_n) begin
      check_eq("rst_ack", DATA_W'(ack_o), '0);
      check_eq("rst_ren", DATA_W'(sram_ren_o), '0);
      check_eq("rst_addr", DATA_W'(sram_addr_o), '0);
      check_eq("rst_rvalid", DATA_W'(rvalid_o), '0);
      for (int i = 0; i < NUM_REQ; i++) check_eq("rst_rdata", rdata_o[i*DATA_W +: DATA_W], '0);
      m_busy = 0; m_owner = 0; m_rr = 0; m_addr = '0;
      for (int q = 0; q <= k; q++) h_fire[q] = 0;
      return;
    end

    e_ack = m_busy ? NUM_REQ'(1 << m_owner) : '0;
    e_ren = (k >= 1) && h_fire[k-1];
    j = k - 1 - RD_LAT;
    e_rv = '0; rv_port = -1; e_data = '0;
    if (j >= 0 && h_fire[j]) begin
      rv_port = h_port[j];
      e_rv    = NUM_REQ'(1 << rv_port);
      e_data  = mem_val(h_addr[j]);
    end
    check_eq("ack", DATA_W'(ack_o), DATA_W'(e_ack));
    check_eq("sram_ren", DATA_W'(sram_ren_o), DATA_W'(e_ren));
    check_eq("sram_addr", DATA_W'(sram_addr_o), DATA_W'(m_addr));
    check_eq("rvalid", DATA_W'(rvalid_o), DATA_W'(e_rv));
    for (int i = 0; i < NUM_REQ; i++)
      check_eq($sformatf("rdata%0d", i), rdata_o[i*DATA_W +: DATA_W],
               (i == rv_port) ? e_data : '0);

    h_fire[k] = 0;
    if (m_busy) begin
      fire = v_req[m_owner] && !v_reb[m_owner];
      if (fire) begin
        h_fire[k] = 1;
        h_port[k] = m_owner;
        h_addr[k] = v_addr[m_owner];
        m_addr    = v_addr[m_owner];
        p_left[m_owner]--;
        p_addr[m_owner]++;
        if (v_last[m_owner]) begin
          m_busy = 0;
          m_rr   = (m_owner + 1) % NUM_REQ;
        end
      end
    end else begin
      for (int off = 0; off < NUM_REQ; off++) begin
        int c;
        c = (m_rr + off) % NUM_REQ;
        if (!m_busy && v_req[c] && v_rid[c] == RID_W'(BANK_ID)) begin
          m_busy  = 1;
          m_owner = c;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_i = '0; rid_i = '0; addr_i = '0; reb_i = '1; rlast_i = '0;
    sram_rdata_i = '0;
    m_busy = 0; m_owner = 0; m_rr = 0; m_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      p_left[i] = 0; p_hold[i] = 0; p_addr[i] = '0;
      v_req[i] = 0; v_rid[i] = '0; v_addr[i] = '0; v_reb[i] = 1; v_last[i] = 0;
    end
    for (int q = 0; q < NCYC; q++) begin
      h_fire[q] = 0; h_port[q] = 0; h_addr[q] = '0; d_ren[q] = 0; d_addr[q] = '0;
    end
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      cyc   = k;
      rst_n = !((k < 3) || (k >= 1400 && k < 1402) || (k >= 2200 && k < 2203));
      drive_ports(k);
      drive_sram(k);
      @(negedge clk);
      check_and_model(k);
    end
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
